// File: rtl/data_mem_loader.sv
// rtl/data_mem_loader.sv - data memory with framed UART byte loader
// Optional trailing checksum word per frame: define LOAD_CKSUM_EN.
module data_mem_loader #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int INIT_IDX = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_cnt,
  output logic              load_err
);

  localparam int BPW   = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_CKSUM = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0]   LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [BCW-1:0]    BC_ONE  = BCW'(1);
  localparam logic [BCW-1:0]    BC_LAST = BCW'(BPW - 1);

  logic [1:0]        state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] ptr;
  logic [BCW-1:0]    byte_cnt;
  logic [DATA_W-1:0] asm_word;
  logic [DATA_W+7:0] shift_word;
  logic [DATA_W-1:0] new_word;
  logic              word_ready;
  logic              start_ok;

  // Big-endian packing: earlier bytes shift toward the MS end.
  assign shift_word = {asm_word, rx_byte};
  assign new_word   = shift_word[DATA_W-1:0];
  assign word_ready = rx_valid && (byte_cnt == BC_LAST);
  assign start_ok   = load_start && ((state == S_IDLE) || (state == S_DONE));

  assign busy      = (state == S_LOAD) || (state == S_CKSUM);
  assign load_done = (state == S_DONE);
  assign load_cnt  = cnt;
  assign rdata     = mem[addr];

`ifdef LOAD_CKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              err;
  assign load_err = err;
`else
  assign load_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      len      <= '0;
      cnt      <= '0;
      ptr      <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
`ifdef LOAD_CKSUM_EN
      sum      <= '0;
      err      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state    <= S_LOAD;
            len      <= ((load_len == '0) || (load_len > LEN_MAX)) ? LEN_MAX : load_len;
            cnt      <= '0;
            ptr      <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
`ifdef LOAD_CKSUM_EN
            sum      <= '0;
            err      <= 1'b0;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (rx_valid) begin
            asm_word <= new_word;
            byte_cnt <= word_ready ? '0 : byte_cnt + BC_ONE;
          end
          if (word_ready) begin
            ptr <= ptr + PTR_ONE;
            cnt <= cnt + CNT_ONE;
`ifdef LOAD_CKSUM_EN
            sum <= sum + new_word;
            if ((cnt + CNT_ONE) == len) state <= S_CKSUM;
`else
            if ((cnt + CNT_ONE) == len) state <= S_DONE;
`endif
          end
        end
`ifdef LOAD_CKSUM_EN
        S_CKSUM: begin
          if (rx_valid) begin
            asm_word <= new_word;
            byte_cnt <= word_ready ? '0 : byte_cnt + BC_ONE;
          end
          if (word_ready) begin
            err   <= (new_word != sum);
            state <= S_DONE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // The loader owns the array while busy, so CPU writes are only taken when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
      end
    end else if ((state == S_LOAD) && word_ready) begin
      mem[ptr] <= new_word;
    end else if (we && !busy) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_loader.sv
// tb/tb_data_mem_loader.sv - scoreboard bench for data_mem_loader
// Also exercises the checksum path when LOAD_CKSUM_EN is defined.
module tb_data_mem_loader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic [7:0]        rx_byte = '0;
  logic              rx_valid = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              load_done;
  logic [ADDR_W:0]   load_cnt;
  logic              load_err;

  data_mem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_IDX(1)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .load_done(load_done), .load_cnt(load_cnt),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mdl [DEPTH];
  logic [15:0] asm_b;
  logic [15:0] msum;
  int          nb;
  int          mptr;
  int          checks = 0;
  int          errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 16'(i);
  endtask

  task automatic model_byte(input logic [7:0] b);
    asm_b = {asm_b[7:0], b};
    nb++;
    if (nb == 2) begin
      mdl[mptr] = asm_b;
      exp_q.push_back({4'(mptr), asm_b});
      msum = msum + asm_b;
      mptr = (mptr + 1) % DEPTH;
      nb = 0;
    end
  endtask

  task automatic start_frame(input logic [ADDR_W:0] len);
    load_len = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    mptr = 0;
    nb = 0;
    asm_b = '0;
    msum = '0;
  endtask

  task automatic send(input logic [7:0] b, input bit in_frame);
    rx_byte = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    if (in_frame) model_byte(b);
  endtask

  // Last data byte of a frame; in checksum builds the correct checksum follows.
  task automatic send_last(input logic [7:0] b);
    send(b, 1'b1);
`ifdef LOAD_CKSUM_EN
    send(msum[15:8], 1'b0);
    send(msum[7:0], 1'b0);
`endif
  endtask

  task automatic drain_q(input string name);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      addr = e.a;
      #1;
      checks++;
      if (rdata !== e.d) begin
        errors++;
        $display("FAIL %s mem[%0d]: got %h expected %h", name, e.a, rdata, e.d);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_init();
    repeat (2) tick();
    addr = 4'd5;
    #1;
    checks++;
    if (rdata !== 16'h0005) begin errors++; $display("FAIL reset_rdata5: got %h expected 0005", rdata); end
    checks++;
    if (busy !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL reset_status: got busy=%b done=%b expected 0 0", busy, load_done); end
    checks++;
    if (load_cnt !== 5'd0 || load_err !== 1'b0) begin errors++; $display("FAIL reset_cnt_err: got cnt=%0d err=%b expected 0 0", load_cnt, load_err); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load2();
    start_frame(5'd2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL load2_busy: got %b expected 1", busy); end
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    send(8'hAB, 1'b1);
    checks++;
    if (load_done !== 1'b0) begin errors++; $display("FAIL load2_early_done: got %b expected 0", load_done); end
    send_last(8'hCD);
    checks++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL load2_done: got done=%b busy=%b expected 1 0", load_done, busy); end
    checks++;
    if (load_cnt !== 5'd2) begin errors++; $display("FAIL load2_cnt: got %0d expected 2", load_cnt); end
    checks++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL load2_err: got %b expected 0", load_err); end
    tick();
    checks++;
    if (load_done !== 1'b0 || load_cnt !== 5'd2) begin errors++; $display("FAIL load2_after: got done=%b cnt=%0d expected 0 2", load_done, load_cnt); end
    drain_q("load2");
    addr = 4'd2;
    #1;
    checks++;
    if (rdata !== 16'h0002) begin errors++; $display("FAIL load2_mem2: got %h expected 0002", rdata); end
  endtask

  task automatic test_full();
    int done_cnt;
    done_cnt = 0;
    start_frame(5'd0);
    for (int i = 0; i < 31; i++) begin
      send(8'(i * 37 + 5), 1'b1);
      if (load_done === 1'b1) done_cnt++;
    end
    send_last(8'hE7);
    if (load_done === 1'b1) done_cnt++;
    tick();
    if (load_done === 1'b1) done_cnt++;
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt); end
    checks++;
    if (load_cnt !== 5'd16) begin errors++; $display("FAIL full_cnt: got %0d expected 16", load_cnt); end
    send(8'h5A, 1'b0);
    checks++;
    if (load_cnt !== 5'd16 || busy !== 1'b0) begin errors++; $display("FAIL full_extra_byte: got cnt=%0d busy=%b expected 16 0", load_cnt, busy); end
    drain_q("full");
  endtask

  task automatic test_cpu_block();
    logic [15:0] old3;
    old3 = mdl[3];
    start_frame(5'd2);
    send(8'h55, 1'b1);
    we = 1'b1; addr = 4'd3; wdata = 16'hFFFF;
    load_len = 5'd1; load_start = 1'b1;
    tick();
    we = 1'b0; load_start = 1'b0;
    send(8'h66, 1'b1);
    checks++;
    if (busy !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL busy_start_ignored: got busy=%b done=%b expected 1 0", busy, load_done); end
    send(8'h77, 1'b1);
    send_last(8'h88);
    checks++;
    if (load_done !== 1'b1) begin errors++; $display("FAIL cpu_frame_done: got %b expected 1", load_done); end
    tick();
    addr = 4'd3;
    #1;
    checks++;
    if (rdata !== old3) begin errors++; $display("FAIL cpu_write_dropped: got %h expected %h", rdata, old3); end
    drain_q("cpu_frame");
    we = 1'b1; addr = 4'd3; wdata = 16'hFFFF;
    #1;
    checks++;
    if (rdata !== old3) begin errors++; $display("FAIL rdw_old: got %h expected %h", rdata, old3); end
    tick();
    we = 1'b0;
    mdl[3] = 16'hFFFF;
    checks++;
    if (rdata !== 16'hFFFF) begin errors++; $display("FAIL cpu_write_idle: got %h expected ffff", rdata); end
  endtask

  task automatic test_reset_midframe();
    start_frame(5'd2);
    send(8'h12, 1'b1);
    reset = 1'b0;
    model_init();
    addr = 4'd0;
    #2;
    checks++;
    if (busy !== 1'b0 || load_cnt !== 5'd0) begin errors++; $display("FAIL midreset_status: got busy=%b cnt=%0d expected 0 0", busy, load_cnt); end
    checks++;
    if (rdata !== 16'h0000) begin errors++; $display("FAIL midreset_mem0: got %h expected 0000", rdata); end
    tick();
    reset = 1'b1;
    tick();
    start_frame(5'd1);
    send(8'h9A, 1'b1);
    send_last(8'hBC);
    checks++;
    if (load_done !== 1'b1 || load_cnt !== 5'd1) begin errors++; $display("FAIL midreset_newframe: got done=%b cnt=%0d expected 1 1", load_done, load_cnt); end
    tick();
    drain_q("midreset");
    addr = 4'd1;
    #1;
    checks++;
    if (rdata !== 16'h0001) begin errors++; $display("FAIL midreset_mem1: got %h expected 0001", rdata); end
  endtask

`ifdef LOAD_CKSUM_EN
  task automatic test_cksum();
    start_frame(5'd2);
    send(8'h12, 1'b1); send(8'h34, 1'b1); send(8'hAB, 1'b1); send(8'hCD, 1'b1);
    checks++;
    if (busy !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL cksum_wait: got busy=%b done=%b expected 1 0", busy, load_done); end
    send(8'hBE, 1'b0); send(8'h01, 1'b0);
    checks++;
    if (load_done !== 1'b1 || load_err !== 1'b0) begin errors++; $display("FAIL cksum_good: got done=%b err=%b expected 1 0", load_done, load_err); end
    tick();
    drain_q("cksum");
    start_frame(5'd2);
    send(8'h12, 1'b1); send(8'h34, 1'b1); send(8'hAB, 1'b1); send(8'hCD, 1'b1);
    send(8'hBE, 1'b0); send(8'h02, 1'b0);
    checks++;
    if (load_err !== 1'b1) begin errors++; $display("FAIL cksum_bad: got %b expected 1", load_err); end
    tick();
    checks++;
    if (load_err !== 1'b1) begin errors++; $display("FAIL cksum_hold: got %b expected 1", load_err); end
    drain_q("cksum_bad");
    start_frame(5'd1);
    checks++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL cksum_clear: got %b expected 0", load_err); end
  endtask
`endif

  initial begin
    nb = 0;
    mptr = 0;
    asm_b = '0;
    msum = '0;
    test_reset();
    test_load2();
    test_full();
    test_cpu_block();
    test_reset_midframe();
`ifdef LOAD_CKSUM_EN
    test_cksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
